// File: rtl/piano_pkg.sv
// Shared types and constants for the piano song sequencer.
package piano_pkg;

  // Note codes as stored in the RAM word and driven on play_note.
  typedef enum logic [1:0] {
    NOTE_NONE = 2'b00,
    NOTE_DO   = 2'b01,
    NOTE_RE   = 2'b10,
    NOTE_MI   = 2'b11
  } note_e;

  // Sequencer control states.
  typedef enum logic [2:0] {
    ST_IDLE       = 3'd0,
    ST_REC_WAIT   = 3'd1,
    ST_REC_HOLD   = 3'd2,
    ST_REC_WRITE  = 3'd3,
    ST_PLAY_FETCH = 3'd4,
    ST_PLAY_LOAD  = 3'd5,
    ST_PLAY_WAIT  = 3'd6,
    ST_PLAY_SOUND = 3'd7
  } state_e;

  // RAM word layout at the default 13-bit time width: {note, start, duration}.
  localparam int unsigned WORD_NOTE_HI  = 27;
  localparam int unsigned WORD_NOTE_LO  = 26;
  localparam int unsigned WORD_START_HI = 25;
  localparam int unsigned WORD_START_LO = 13;
  localparam int unsigned WORD_DUR_HI   = 12;
  localparam int unsigned WORD_DUR_LO   = 0;

  // Key bits are [2] do, [1] re, [0] mi; do wins over re wins over mi.
  function automatic note_e key_to_note(input logic [2:0] keys);
    note_e n;
    n = NOTE_NONE;
    if (keys[2])      n = NOTE_DO;
    else if (keys[1]) n = NOTE_RE;
    else if (keys[0]) n = NOTE_MI;
    return n;
  endfunction

  // Level of the single key that corresponds to a latched note.
  function automatic logic note_key_held(input note_e note, input logic [2:0] keys);
    logic held;
    held = 1'b0;
    case (note)
      NOTE_DO: held = keys[2];
      NOTE_RE: held = keys[1];
      NOTE_MI: held = keys[0];
      default: held = 1'b0;
    endcase
    return held;
  endfunction

endpackage

// File: rtl/song_timer.sv
// Song timer: counts ticks while enabled, clears on session start,
// saturates at all-ones.
module song_timer #(
  parameter int unsigned TIME_W = 13
) (
  input  logic              i_clk,
  input  logic              i_rst,
  input  logic              i_clear,
  input  logic              i_enable,
  input  logic              i_tick,
  output logic [TIME_W-1:0] o_time
);

  logic [TIME_W-1:0] r_time;

  // Tick counter with clear priority and saturation.
  always_ff @(posedge i_clk or posedge i_rst) begin
    if (i_rst) begin
      r_time <= '0;
    end else if (i_clear) begin
      r_time <= '0;
    end else if (i_enable && i_tick && (r_time != '1)) begin
      r_time <= r_time + TIME_W'(1);
    end
  end

  assign o_time = r_time;

endmodule

// File: rtl/song_sequencer.sv
// Record/playback controller for the note RAM. Records {note, start, duration}
// entries against the song timer and replays them in order.
module song_sequencer
  import piano_pkg::*;
#(
  parameter int unsigned ADDR_W = 13,
  parameter int unsigned TIME_W = 13
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  tick,
  input  logic                  mode,
  input  logic                  start,
  input  logic                  stop,
  input  logic [2:0]            key_down,
  output logic [ADDR_W-1:0]     ram_addr,
  output logic                  ram_wren,
  output logic [2+2*TIME_W-1:0] ram_wdata,
  input  logic [2+2*TIME_W-1:0] ram_q,
  output logic [1:0]            play_note,
  output logic                  busy,
  output logic [ADDR_W-1:0]     entry_count,
  output logic                  full
);

  localparam int unsigned WORD_W = 2 + 2*TIME_W;
  localparam logic [ADDR_W-1:0] ENTRY_MAX = '1;

  state_e              r_state;
  state_e              w_state_next;

  logic [TIME_W-1:0]   w_time;
  logic                w_start_go;
  logic                w_timer_en;

  // Record-side latches
  note_e               r_note;
  logic [TIME_W-1:0]   r_start_time;
  logic [TIME_W-1:0]   w_duration;
  logic                w_any_key;
  logic                w_held;

  // Play-side registers
  note_e               r_cur_note;
  logic [TIME_W-1:0]   r_cur_start;
  logic [TIME_W-1:0]   r_cur_dur;
  logic [TIME_W-1:0]   r_remain;
  logic [ADDR_W-1:0]   r_idx;
  logic [ADDR_W-1:0]   w_idx_inc;
  logic                w_last;
  logic                w_at_start;

  // Registered outputs and their next values
  logic [ADDR_W-1:0]   r_ram_addr,    w_ram_addr_next;
  logic                r_ram_wren,    w_ram_wren_next;
  logic [WORD_W-1:0]   r_ram_wdata,   w_ram_wdata_next;
  note_e               r_play_note,   w_play_note_next;
  logic                r_busy,        w_busy_next;
  logic [ADDR_W-1:0]   r_entry_count, w_entry_count_next;
  logic                r_full;
  logic [ADDR_W-1:0]   w_idx_next;

  assign w_start_go = (r_state == ST_IDLE) && start && !stop;
  assign w_timer_en = (r_state != ST_IDLE);

  song_timer #(.TIME_W(TIME_W)) u_timer (
    .i_clk    (clock),
    .i_rst    (reset),
    .i_clear  (w_start_go),
    .i_enable (w_timer_en),
    .i_tick   (tick),
    .o_time   (w_time)
  );

  assign w_any_key  = |key_down;
  assign w_held     = note_key_held(r_note, key_down);
  assign w_duration = w_time - r_start_time;
  assign w_idx_inc  = r_idx + ADDR_W'(1);
  assign w_last     = (w_idx_inc == r_entry_count);
  assign w_at_start = (w_time >= r_cur_start);

  // State register.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) r_state <= ST_IDLE;
    else       r_state <= w_state_next;
  end

  // Next-state logic; stop overrides everything, including start.
  always_comb begin
    w_state_next = r_state;
    if (stop) begin
      w_state_next = ST_IDLE;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (start) begin
            if (!mode)                      w_state_next = ST_REC_WAIT;
            else if (r_entry_count != '0)   w_state_next = ST_PLAY_FETCH;
          end
        end
        ST_REC_WAIT:   if (w_any_key && !r_full) w_state_next = ST_REC_HOLD;
        ST_REC_HOLD:   if (!w_held)              w_state_next = ST_REC_WRITE;
        ST_REC_WRITE:  w_state_next = ST_REC_WAIT;
        ST_PLAY_FETCH: w_state_next = ST_PLAY_LOAD;
        ST_PLAY_LOAD:  w_state_next = ST_PLAY_WAIT;
        ST_PLAY_WAIT: begin
          if (w_at_start) begin
            if (r_cur_dur != '0) w_state_next = ST_PLAY_SOUND;
            else                 w_state_next = w_last ? ST_IDLE : ST_PLAY_FETCH;
          end
        end
        ST_PLAY_SOUND: begin
          // Leaving on the tick that takes remain from 1 to 0 keeps the
          // note length exact instead of adding an idle cycle at zero.
          if (tick && (r_remain == TIME_W'(1)))
            w_state_next = w_last ? ST_IDLE : ST_PLAY_FETCH;
        end
        default: w_state_next = ST_IDLE;
      endcase
    end
  end

  // Output and datapath next values, derived from the upcoming state so
  // every output can be registered without adding latency.
  always_comb begin
    w_ram_addr_next    = r_ram_addr;
    w_ram_wdata_next   = r_ram_wdata;
    w_ram_wren_next    = 1'b0;
    w_play_note_next   = NOTE_NONE;
    w_busy_next        = (w_state_next != ST_IDLE);
    w_idx_next         = r_idx;
    w_entry_count_next = r_entry_count;

    if (r_state == ST_REC_WRITE)
      w_entry_count_next = r_entry_count + ADDR_W'(1);
    else if (w_start_go && !mode)
      w_entry_count_next = '0;

    if (w_state_next == ST_PLAY_FETCH)
      w_idx_next = (r_state == ST_IDLE) ? '0 : w_idx_inc;

    case (w_state_next)
      ST_REC_WRITE: begin
        w_ram_wren_next  = 1'b1;
        w_ram_addr_next  = r_entry_count;
        w_ram_wdata_next = {r_note, r_start_time, w_duration};
      end
      ST_PLAY_FETCH: w_ram_addr_next  = w_idx_next;
      ST_PLAY_SOUND: w_play_note_next = r_cur_note;
      default: ;
    endcase
  end

  // Registered outputs and counters.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_ram_addr    <= '0;
      r_ram_wren    <= 1'b0;
      r_ram_wdata   <= '0;
      r_play_note   <= NOTE_NONE;
      r_busy        <= 1'b0;
      r_entry_count <= '0;
      r_full        <= 1'b0;
      r_idx         <= '0;
    end else begin
      r_ram_addr    <= w_ram_addr_next;
      r_ram_wren    <= w_ram_wren_next;
      r_ram_wdata   <= w_ram_wdata_next;
      r_play_note   <= w_play_note_next;
      r_busy        <= w_busy_next;
      r_entry_count <= w_entry_count_next;
      r_full        <= (w_entry_count_next == ENTRY_MAX);
      r_idx         <= w_idx_next;
    end
  end

  // Record latches, fetched entry and playback countdown.
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      r_note       <= NOTE_NONE;
      r_start_time <= '0;
      r_cur_note   <= NOTE_NONE;
      r_cur_start  <= '0;
      r_cur_dur    <= '0;
      r_remain     <= '0;
    end else begin
      if ((r_state == ST_REC_WAIT) && (w_state_next == ST_REC_HOLD)) begin
        r_note       <= key_to_note(key_down);
        r_start_time <= w_time;
      end
      if (r_state == ST_PLAY_LOAD) begin
        r_cur_note  <= note_e'(ram_q[WORD_W-1 -: 2]);
        r_cur_start <= ram_q[2*TIME_W-1 -: TIME_W];
        r_cur_dur   <= ram_q[TIME_W-1:0];
      end
      if ((r_state == ST_PLAY_WAIT) && (w_state_next == ST_PLAY_SOUND))
        r_remain <= r_cur_dur;
      else if ((r_state == ST_PLAY_SOUND) && tick)
        r_remain <= r_remain - TIME_W'(1);
    end
  end

  assign ram_addr    = r_ram_addr;
  assign ram_wren    = r_ram_wren;
  assign ram_wdata   = r_ram_wdata;
  assign play_note   = r_play_note;
  assign busy        = r_busy;
  assign entry_count = r_entry_count;
  assign full        = r_full;

endmodule

// File: doc/song_sequencer.md
# song_sequencer

Record/playback controller for the piano's 8192x28 note RAM. In record mode it timestamps key presses against a 0.01 s tick, then writes one `{note, start_time, duration}` entry per completed note. In play mode it fetches entries in order and drives the held note at the recorded times. It sits between the key inputs and the tick source on one side, and the RAM and the sound/VGA note consumers on the other.

## Interface
- `ADDR_W`, 13, RAM address width; capacity is 2^ADDR_W−1 entries.
- `TIME_W`, 13, width of the time stamp and duration fields.
- `clock`  in  1  system clock (50 MHz).
- `reset`  in  1  asynchronous, active-high reset.
- `tick`  in  1  one-cycle pulse every 0.01 s.
- `mode`  in  1  0 = record, 1 = play; sampled only on `start`.
- `start`  in  1  one-cycle pulse that begins a session from IDLE.
- `stop`  in  1  one-cycle pulse that aborts any session and returns to IDLE.
- `key_down`  in  3  synchronised, active-high keys: [2] do, [1] re, [0] mi.
- `ram_addr`  out  ADDR_W  RAM address.
- `ram_wren`  out  1  RAM write strobe.
- `ram_wdata`  out  2+2·TIME_W  `{note[1:0], start_time, duration}`.
- `ram_q`  in  2+2·TIME_W  RAM read data; valid 1 cycle after `ram_addr`.
- `play_note`  out  2  note sounding during playback: 00 none, 01 do, 10 re, 11 mi.
- `busy`  out  1  high whenever state ≠ IDLE.
- `entry_count`  out  ADDR_W  number of entries recorded.
- `full`  out  1  `entry_count` == 2^ADDR_W−1.

## Operation
- **Song timer.**
  - `song_time` (TIME_W bits) clears to 0 on `start`.
  - It increments on `tick` in every non-IDLE state.
  - It saturates at all-ones.
- **State machine:** IDLE, REC_WAIT, REC_HOLD, REC_WRITE, PLAY_FETCH, PLAY_LOAD, PLAY_WAIT, PLAY_SOUND.
- **IDLE.**
  - `start`, `mode`=0 → REC_WAIT; `entry_count` ← 0.
  - `start`, `mode`=1, `entry_count`>0 → PLAY_FETCH; `idx` ← 0.
  - `start`, `mode`=1, `entry_count`=0 → stays in IDLE.
- **REC_WAIT.** When any key is down and not `full`:
  - latch note using priority do > re > mi;
  - latch `start_time` ← `song_time`;
  - go to REC_HOLD.
- **REC_HOLD.**
  - Only the latched key is watched; other keys are ignored.
  - On its release: `duration` ← `song_time` − `start_time` (pre-increment value if `tick` occurs in the same cycle) → REC_WRITE.
- **REC_WRITE.** For exactly one cycle:
  - `ram_wren`=1, `ram_addr`=`entry_count`;
  - then `entry_count`+1 → REC_WAIT.
- **PLAY_FETCH.** `ram_addr` ← `idx` → PLAY_LOAD.
- **PLAY_LOAD.** Register `ram_q` into `cur` → PLAY_WAIT.
- **PLAY_WAIT.**
  - When `song_time` ≥ `cur.start_time` → PLAY_SOUND.
  - `remain` ← `cur.duration`.
  - If `remain`=0, skip the note: `idx`+1, then PLAY_FETCH, or IDLE if `idx`+1 == `entry_count`.
- **PLAY_SOUND.**
  - `play_note` = `cur.note`.
  - `remain` decrements on `tick`.
  - At 0: `idx`+1, then PLAY_FETCH, or IDLE if finished.
- **Boundaries.**
  - **Full:** if `full` in REC_WAIT, presses are ignored and the state stays REC_WAIT.
  - **Stop:** `stop` in any state → IDLE next cycle; `play_note`=00; `ram_wren`=0; no partial entry is written. `stop` has priority over `start`.
  - **Simultaneous presses:** keys pressed in the same cycle resolve by priority.
  - **Held key at start:** a key already held when record starts is captured at `song_time`=0.
  - **Asynchronous reset:** clears all state mid-operation.

## Timing
- **Reset values:**
  - state IDLE;
  - `ram_addr` 0, `ram_wren` 0, `ram_wdata` 0;
  - `play_note` 00, `busy` 0, `entry_count` 0, `full` 0;
  - `song_time`, `idx`, `remain` all 0.
- **Record write:** `ram_wren` asserts on the cycle after the release is seen.
- **Playback fetch:** 2 cycles from PLAY_FETCH to `cur` valid.
- **Note onset:** `play_note` changes 1 cycle after the `start_time` comparison succeeds.
- **Note length:** playback sounds for `duration` ticks ±1 cycle.
- **Outputs:** all outputs are registered.

## Structure
- Package `piano_pkg` holds:
  - note codes NOTE_NONE/DO/RE/MI;
  - the state enum;
  - field offsets of the RAM word (note [27:26], start [25:13], duration [12:0]).
- One natural sub-module: `song_timer`, which handles tick counting, clear and saturation.

## Test plan
- **Record one note:** `start`, `mode`=0; hold do from tick 5 to tick 17 → one write at addr 0 of `{01, 5, 12}`; `entry_count`=1.
- **Press priority:** re and mi pressed in the same cycle, released at tick 3 → entry note 10; the mi release is ignored.
- **Playback:** RAM holds `{11,2,4}` and `{01,10,3}`, `entry_count`=2 → `play_note` is 11 for ticks 2–5, 00, then 01 for ticks 10–12, then IDLE with `busy`=0.
- **Zero duration:** entry `{10,0,0}` → `play_note` stays 00, `idx` advances.
- **Full:** preload `entry_count`=8191 → presses produce no write and `full`=1.
- **Abort/reset:** `stop` during REC_HOLD → no write, IDLE. Asserting `reset` during PLAY_SOUND → all outputs return to reset values immediately.
